// File: rtl/cpumc_arbiter.sv
// -----------------------------------------------------------------------------
// cpumc_arbiter
//
// Shares the CPU memory bus (cpumc) between the debugger host interface (HCI),
// the sprite DMA engine and the CPU core. Priority is HCI > DMA > CPU and an
// owner is never preempted. Every ownership change passes through a park
// phase. During park the bus shows a read of the last driven address, so a
// write cannot leak across the handover.
//
// Parameters:
//   PARK_CYCLES     turnaround cycles between owners (1..15)
//   DMA_MAX_CYCLES  longest continuous DMA ownership before a forced release
//                   (16..65535)
//
// Ports:
//   clk_in, rst_in              clock, synchronous active-high reset
//   hci_req_in / hci_a_in / hci_r_nw_in / hci_d_in
//                               HCI request and bus cycle
//   hci_gnt_out                 HCI owns the bus
//   dma_req_in / dma_a_in / dma_r_nw_in / dma_d_in
//                               DMA request and bus cycle
//   dma_gnt_out                 DMA owns the bus
//   cpu_a_in / cpu_r_nw_in / cpu_d_in
//                               CPU bus cycle
//   cpu_ready_out               CPU READY (0 stalls the CPU)
//   mc_a_out / mc_r_nw_out / mc_d_out
//                               cpumc bus towards PRG, WRAM, PPU and joypad
//   owner_out                   0 = CPU, 1 = PARK, 2 = HCI, 3 = DMA
//   dma_timeout_out             sticky flag for a forced DMA release
// -----------------------------------------------------------------------------
module cpumc_arbiter #(
    parameter int unsigned PARK_CYCLES    = 1,
    parameter int unsigned DMA_MAX_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        hci_req_in,
    input  logic [15:0] hci_a_in,
    input  logic        hci_r_nw_in,
    input  logic [7:0]  hci_d_in,
    output logic        hci_gnt_out,
    input  logic        dma_req_in,
    input  logic [15:0] dma_a_in,
    input  logic        dma_r_nw_in,
    input  logic [7:0]  dma_d_in,
    output logic        dma_gnt_out,
    input  logic [15:0] cpu_a_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic        cpu_ready_out,
    output logic [15:0] mc_a_out,
    output logic        mc_r_nw_out,
    output logic [7:0]  mc_d_out,
    output logic [1:0]  owner_out,
    output logic        dma_timeout_out
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_PARK = 2'd1,
        S_HCI  = 2'd2,
        S_DMA  = 2'd3
    } state_t;

    localparam logic [3:0]  PARK_LAST = 4'(PARK_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(DMA_MAX_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  park_cnt_r;
    logic [15:0] hold_cnt_r;
    logic [15:0] held_a_r;
    logic        dma_block_r;
    logic        dma_timeout_r;
    logic        cpu_ready_r;
    logic        hci_gnt_r;
    logic        dma_gnt_r;
    logic [1:0]  owner_r;
    logic        dma_ok_s;
    logic        force_rel_s;
    logic [15:0] bus_a_s;
    logic        bus_r_nw_s;
    logic [7:0]  bus_d_s;

    // Next-owner decision; DMA stays ineligible after a forced release until
    // its request has been seen low once.
    always_comb begin
        dma_ok_s    = dma_req_in & ~dma_block_r;
        state_nxt_s = state_r;
        force_rel_s = 1'b0;
        case (state_r)
            S_CPU: begin
                if (hci_req_in || dma_ok_s) begin
                    state_nxt_s = S_PARK;
                end else begin
                    state_nxt_s = S_CPU;
                end
            end
            S_PARK: begin
                // Winner is re-evaluated at exit, so a request that vanished
                // during park hands the bus back to the CPU without a pulse.
                if (park_cnt_r == PARK_LAST) begin
                    if (hci_req_in) begin
                        state_nxt_s = S_HCI;
                    end else if (dma_ok_s) begin
                        state_nxt_s = S_DMA;
                    end else begin
                        state_nxt_s = S_CPU;
                    end
                end else begin
                    state_nxt_s = S_PARK;
                end
            end
            S_HCI: begin
                if (!hci_req_in) begin
                    state_nxt_s = S_PARK;
                end else begin
                    state_nxt_s = S_HCI;
                end
            end
            S_DMA: begin
                if (!dma_req_in) begin
                    state_nxt_s = S_PARK;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = S_PARK;
                    force_rel_s = 1'b1;
                end else begin
                    state_nxt_s = S_DMA;
                end
            end
            default: begin
                state_nxt_s = S_CPU;
            end
        endcase
    end

    // Arbiter FSM, counters, park address holder and registered status outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= S_CPU;
            park_cnt_r    <= 4'd0;
            hold_cnt_r    <= 16'd0;
            held_a_r      <= 16'h0000;
            dma_block_r   <= 1'b0;
            dma_timeout_r <= 1'b0;
            cpu_ready_r   <= 1'b1;
            hci_gnt_r     <= 1'b0;
            dma_gnt_r     <= 1'b0;
            owner_r       <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            cpu_ready_r <= (state_nxt_s == S_CPU);
            hci_gnt_r   <= (state_nxt_s == S_HCI);
            dma_gnt_r   <= (state_nxt_s == S_DMA);
            owner_r     <= state_nxt_s;

            if ((state_r == S_PARK) && (state_nxt_s == S_PARK)) begin
                park_cnt_r <= park_cnt_r + 4'd1;
            end else begin
                park_cnt_r <= 4'd0;
            end

            if ((state_r == S_DMA) && (state_nxt_s == S_DMA)) begin
                hold_cnt_r <= hold_cnt_r + 16'd1;
            end else begin
                hold_cnt_r <= 16'd0;
            end

            // Park keeps showing the address of the last owned cycle.
            if (state_r != S_PARK) begin
                held_a_r <= bus_a_s;
            end else begin
                held_a_r <= held_a_r;
            end

            if (force_rel_s) begin
                dma_block_r <= 1'b1;
            end else if (!dma_req_in) begin
                dma_block_r <= 1'b0;
            end else begin
                dma_block_r <= dma_block_r;
            end

            if (force_rel_s) begin
                dma_timeout_r <= 1'b1;
            end else begin
                dma_timeout_r <= dma_timeout_r;
            end
        end
    end

    // Bus distribution selected by the registered owner.
    always_comb begin
        bus_a_s    = cpu_a_in;
        bus_r_nw_s = cpu_r_nw_in;
        bus_d_s    = cpu_d_in;
        case (state_r)
            S_CPU: begin
                bus_a_s    = cpu_a_in;
                bus_r_nw_s = cpu_r_nw_in;
                bus_d_s    = cpu_d_in;
            end
            S_PARK: begin
                bus_a_s    = held_a_r;
                bus_r_nw_s = 1'b1;
                bus_d_s    = 8'h00;
            end
            S_HCI: begin
                bus_a_s    = hci_a_in;
                bus_r_nw_s = hci_r_nw_in;
                bus_d_s    = hci_d_in;
            end
            S_DMA: begin
                bus_a_s    = dma_a_in;
                bus_r_nw_s = dma_r_nw_in;
                bus_d_s    = dma_d_in;
            end
            default: begin
                bus_a_s    = cpu_a_in;
                bus_r_nw_s = cpu_r_nw_in;
                bus_d_s    = cpu_d_in;
            end
        endcase
    end

    assign mc_a_out        = bus_a_s;
    assign mc_r_nw_out     = bus_r_nw_s;
    assign mc_d_out        = bus_d_s;
    assign cpu_ready_out   = cpu_ready_r;
    assign hci_gnt_out     = hci_gnt_r;
    assign dma_gnt_out     = dma_gnt_r;
    assign owner_out       = owner_r;
    assign dma_timeout_out = dma_timeout_r;

endmodule

// File: tb/tb_cpumc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpumc_arbiter
//
// Self-checking bench for cpumc_arbiter. Every driven cycle pushes the
// expected outputs, taken from a cycle-level reference model of the bus
// ownership rules, into a queue. A monitor on the falling clock edge pops and
// compares them.
// -----------------------------------------------------------------------------
module tb_cpumc_arbiter;

    localparam int P = 2;      // PARK_CYCLES under test
    localparam int M = 100;    // DMA_MAX_CYCLES under test

    localparam int OWN_CPU  = 0;
    localparam int OWN_PARK = 1;
    localparam int OWN_HCI  = 2;
    localparam int OWN_DMA  = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        hci_req_in = 1'b0;
    logic [15:0] hci_a_in = 16'h0000;
    logic        hci_r_nw_in = 1'b1;
    logic [7:0]  hci_d_in = 8'h00;
    logic        hci_gnt_out;
    logic        dma_req_in = 1'b0;
    logic [15:0] dma_a_in = 16'h0000;
    logic        dma_r_nw_in = 1'b1;
    logic [7:0]  dma_d_in = 8'h00;
    logic        dma_gnt_out;
    logic [15:0] cpu_a_in = 16'h0000;
    logic        cpu_r_nw_in = 1'b1;
    logic [7:0]  cpu_d_in = 8'h00;
    logic        cpu_ready_out;
    logic [15:0] mc_a_out;
    logic        mc_r_nw_out;
    logic [7:0]  mc_d_out;
    logic [1:0]  owner_out;
    logic        dma_timeout_out;

    cpumc_arbiter #(
        .PARK_CYCLES    (P),
        .DMA_MAX_CYCLES (M)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hci_req_in      (hci_req_in),
        .hci_a_in        (hci_a_in),
        .hci_r_nw_in     (hci_r_nw_in),
        .hci_d_in        (hci_d_in),
        .hci_gnt_out     (hci_gnt_out),
        .dma_req_in      (dma_req_in),
        .dma_a_in        (dma_a_in),
        .dma_r_nw_in     (dma_r_nw_in),
        .dma_d_in        (dma_d_in),
        .dma_gnt_out     (dma_gnt_out),
        .cpu_a_in        (cpu_a_in),
        .cpu_r_nw_in     (cpu_r_nw_in),
        .cpu_d_in        (cpu_d_in),
        .cpu_ready_out   (cpu_ready_out),
        .mc_a_out        (mc_a_out),
        .mc_r_nw_out     (mc_r_nw_out),
        .mc_d_out        (mc_d_out),
        .owner_out       (owner_out),
        .dma_timeout_out (dma_timeout_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [1:0]  owner;
        logic        ready;
        logic        hg;
        logic        dg;
        logic        rnw;
        logic        to;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    bit   fix_addr = 1'b0;

    // Reference model: who owns the bus, how long the park has left, how
    // many cycles DMA has been served, and whether DMA must first drop.
    int          m_owner = OWN_CPU;
    int          m_park_left = 0;
    int          m_served = 0;
    bit          m_blocked = 1'b0;
    bit          m_timeout = 1'b0;
    logic [15:0] m_held_a = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.owner = 2'(m_owner);
        e.ready = (m_owner == OWN_CPU);
        e.hg    = (m_owner == OWN_HCI);
        e.dg    = (m_owner == OWN_DMA);
        e.to    = m_timeout;
        case (m_owner)
            OWN_CPU:  begin e.a = cpu_a_in; e.rnw = cpu_r_nw_in; e.d = cpu_d_in; end
            OWN_PARK: begin e.a = m_held_a; e.rnw = 1'b1;        e.d = 8'h00;    end
            OWN_HCI:  begin e.a = hci_a_in; e.rnw = hci_r_nw_in; e.d = hci_d_in; end
            default:  begin e.a = dma_a_in; e.rnw = dma_r_nw_in; e.d = dma_d_in; end
        endcase
        return e;
    endfunction

    task automatic model_edge();
        int nxt;
        bit forced;
        nxt = m_owner;
        forced = 1'b0;
        if (rst_in) begin
            m_owner = OWN_CPU; m_park_left = 0; m_served = 0;
            m_blocked = 1'b0; m_timeout = 1'b0; m_held_a = 16'h0000;
        end else begin
            if (m_owner != OWN_PARK) m_held_a = model_outputs().a;
            case (m_owner)
                OWN_CPU: begin
                    if (hci_req_in || (dma_req_in && !m_blocked)) begin
                        nxt = OWN_PARK; m_park_left = P;
                    end
                end
                OWN_PARK: begin
                    m_park_left--;
                    if (m_park_left == 0) begin
                        if (hci_req_in) nxt = OWN_HCI;
                        else if (dma_req_in && !m_blocked) nxt = OWN_DMA;
                        else nxt = OWN_CPU;
                        m_served = 0;
                    end
                end
                OWN_HCI: begin
                    if (!hci_req_in) begin nxt = OWN_PARK; m_park_left = P; end
                end
                default: begin
                    m_served++;
                    if (!dma_req_in) begin
                        nxt = OWN_PARK; m_park_left = P;
                    end else if (m_served == M) begin
                        nxt = OWN_PARK; m_park_left = P; m_timeout = 1'b1; forced = 1'b1;
                    end
                end
            endcase
            if (forced) m_blocked = 1'b1;
            else if (!dma_req_in) m_blocked = 1'b0;
            m_owner = nxt;
        end
    endtask

    // One bus cycle: drive inputs, queue this cycle's expectation, advance.
    task automatic step(input bit rst, input bit hreq, input bit dreq);
        rst_in      = rst;
        hci_req_in  = hreq;
        dma_req_in  = dreq;
        cpu_a_in    = fix_addr ? 16'h8000 : 16'($urandom);
        hci_a_in    = fix_addr ? 16'h2007 : 16'($urandom);
        dma_a_in    = fix_addr ? 16'h0200 : 16'($urandom);
        cpu_r_nw_in = 1'($urandom);
        hci_r_nw_in = 1'($urandom);
        dma_r_nw_in = 1'($urandom);
        cpu_d_in    = 8'($urandom);
        hci_d_in    = 8'($urandom);
        dma_d_in    = 8'($urandom);
        if (check_en) exp_q.push_back(model_outputs());
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: compare every observed cycle against the queued expectation.
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("owner", 16'(owner_out), 16'(mon_e.owner));
            chk("cpu_ready", 16'(cpu_ready_out), 16'(mon_e.ready));
            chk("hci_gnt", 16'(hci_gnt_out), 16'(mon_e.hg));
            chk("dma_gnt", 16'(dma_gnt_out), 16'(mon_e.dg));
            chk("mc_a", mc_a_out, mon_e.a);
            chk("mc_r_nw", 16'(mc_r_nw_out), 16'(mon_e.rnw));
            chk("mc_d", 16'(mc_d_out), 16'(mon_e.d));
            chk("dma_timeout", 16'(dma_timeout_out), 16'(mon_e.to));
            chk("one_grant", 16'(hci_gnt_out & dma_gnt_out), 16'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  hr;
        bit  dr;
        bit  rr;

        // Reset and idle bus with a fixed CPU address.
        fix_addr = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        check_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("idle_mc_a", mc_a_out, 16'h8000);

        // DMA request: stall next cycle, grant after the park phase.
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("dma_stall", 16'(cpu_ready_out), 16'd0);
        cnt = 0;
        while (dma_gnt_out !== 1'b1 && cnt < 10) begin
            step(1'b0, 1'b0, 1'b1);
            cnt++;
        end
        chk("dma_grant_latency", 16'(cnt), 16'(P));
        chk("dma_mc_a", mc_a_out, 16'h0200);
        repeat (50) step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Simultaneous requests: HCI first, then DMA after a park.
        repeat (30) step(1'b0, 1'b1, 1'b1);
        chk("hci_wins", 16'(hci_gnt_out), 16'd1);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Forced DMA release, no re-grant while held, then re-grant.
        fix_addr = 1'b0;
        repeat (250) step(1'b0, 1'b0, 1'b1);
        chk("timeout_flag", 16'(dma_timeout_out), 16'd1);
        chk("no_regrant", 16'(dma_gnt_out), 16'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        chk("regrant", 16'(dma_gnt_out), 16'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // Short pulses dropping during park.
        step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 1'b0);

        // Reset in the middle of DMA ownership.
        repeat (10) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_owner", 16'(owner_out), 16'd0);
        chk("rst_timeout", 16'(dma_timeout_out), 16'd0);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // Random request traffic: short holds, then long holds with resets.
        hr = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) hr = !hr;
            if ($urandom_range(0, 11) == 0) dr = !dr;
            step(1'b0, hr, dr);
        end
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) hr = !hr;
            if ($urandom_range(0, 89) == 0) dr = !dr;
            rr = ($urandom_range(0, 499) == 0);
            step(rr, hr, dr);
        end

        repeat (4) step(1'b0, 1'b0, 1'b0);
        check_en = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
